// File: rtl/ifu.sv
// Single-issue instruction fetch unit: fetches one word, hands it to decode,
// then waits for the commit stage to say where to fetch next.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        imem_rsp_ready,
  output logic        if_out_valid,
  input  logic        if_out_ready,
  output logic [31:0] if_out_pc,
  output logic [31:0] if_out_inst,
  input  logic        commit_valid,
  input  logic        commit_redirect,
  input  logic [31:0] commit_target,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RSP,
    S_SEND,
    S_WAIT_COMMIT
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] inst;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: defaulting state_next to state before the case keeps this block
  // free of inferred latches on every path.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:        state_next = S_REQ;
      S_REQ:         if (imem_req_ready) state_next = S_WAIT_RSP;
      S_WAIT_RSP:    if (imem_rsp_valid) state_next = S_SEND;
      S_SEND:        if (if_out_ready)   state_next = S_WAIT_COMMIT;
      S_WAIT_COMMIT: if (commit_valid)   state_next = S_REQ;
      default:       state_next = S_IDLE;
    endcase
  end

  // Handshake outputs depend on state alone, so no input-to-output paths exist.
  always_comb begin
    imem_req_valid = 1'b0;
    imem_rsp_ready = 1'b0;
    if_out_valid   = 1'b0;
    case (state)
      S_REQ:      imem_req_valid = 1'b1;
      S_WAIT_RSP: imem_rsp_ready = 1'b1;
      S_SEND:     if_out_valid   = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inst        <= NOP_INST;
      fetch_count <= 32'd0;
    end else begin
      if (state == S_WAIT_RSP && imem_rsp_valid)
        inst <= imem_rsp_data;
      if (state == S_SEND && if_out_ready)
        fetch_count <= fetch_count + 32'd1;
      if (state == S_WAIT_COMMIT && commit_valid)
        pc <= commit_redirect ? (commit_target & ALIGN_MASK) : (pc + 32'd4);
    end
  end

  assign imem_addr   = pc & ALIGN_MASK;
  assign if_out_pc   = pc;
  assign if_out_inst = inst;

endmodule
